refill_queue: RTL

- Single-clock, parametrised queue carrying cache-line refill data plus line index from main-memory interface to cache fill logic.
- Successor to the fixed 32x512 main-to-cache FIFO:
  - generic width, depth and index width
  - true simultaneous push+pop
  - occupancy count and almost-full threshold
  - sticky overflow/underflow error flags
- Sits between memory read-return path and cache data-array write port.

---
 rtl/refill_pkg.sv | 23 ++
 rtl/refill_queue_ram.sv | 29 ++
 rtl/refill_queue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/refill_pkg.sv
// Shared definitions for the cache-line refill queue: default widths, entry layout
// and an elaboration-time log2 helper.
package refill_pkg;

    localparam int LINE_BITS     = 512;
    localparam int LINE_IDX_BITS = 7;

    typedef struct packed {
        logic [LINE_IDX_BITS-1:0] addr;
        logic [LINE_BITS-1:0]     data;
    } refill_entry_t;

    // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/refill_queue_ram.sv
// DEPTH x WIDTH storage for the refill queue: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module refill_queue_ram
    import refill_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int WIDTH = LINE_BITS + LINE_IDX_BITS,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/refill_queue.sv
// Single-clock refill queue between the memory read-return path and the cache fill port.
// Optional in-place merge of pushes that hit an occupied line index: REFILL_QUEUE_MERGE_EN.
module refill_queue
    import refill_pkg::*;
#(
    parameter int DATA_WIDTH  = LINE_BITS,
    parameter int ADDR_WIDTH  = LINE_IDX_BITS,
    parameter int DEPTH       = 32,
    parameter int AFULL_LEVEL = DEPTH - 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic [ADDR_WIDTH-1:0]    push_addr,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic [ADDR_WIDTH-1:0]    pop_addr,
    output logic                     pop_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [clog2(DEPTH):0]    count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_err
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_WIDTH + ADDR_WIDTH;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic [ADDR_WIDTH-1:0] pop_addr_q, pop_addr_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;

    logic                  full_s, empty_s;
    logic                  pop_acc_s, new_push_s, merge_s, drop_s;
    logic                  ram_we_s;
    logic [PTR_W-1:0]      ram_waddr_s;
    logic [ENT_W-1:0]      ram_rdata_s;

    assign full_s    = (count_q == CNT_W'(DEPTH));
    assign empty_s   = (count_q == {CNT_W{1'b0}});
    assign pop_acc_s = pop && !empty_s;

`ifdef REFILL_QUEUE_MERGE_EN
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] tag_q [DEPTH];
    logic                  hit_s, hit_head_s;
    logic [PTR_W-1:0]      hit_idx_s, scan_idx_s;

    // Oldest occupied entry (scanning from the head) whose index matches the push.
    always_comb begin
        hit_s      = 1'b0;
        hit_head_s = 1'b0;
        hit_idx_s  = {PTR_W{1'b0}};
        scan_idx_s = {PTR_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx_s = rd_ptr_q + PTR_W'(k);
            if (!hit_s && valid_q[scan_idx_s] && (tag_q[scan_idx_s] == push_addr)) begin
                hit_s      = 1'b1;
                hit_head_s = (k == 0);
                hit_idx_s  = scan_idx_s;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // A head hit that is leaving this cycle must not be merged into; it becomes a new push.
    assign merge_s     = push && hit_s && !(hit_head_s && pop_acc_s);
    assign ram_waddr_s = merge_s ? hit_idx_s : wr_ptr_q;

    // Occupancy bits: the pop clear precedes the push set so a full push+pop keeps the slot live.
    always_comb begin
        valid_d = valid_q;
        if (pop_acc_s) begin
            valid_d[rd_ptr_q] = 1'b0;
        end else begin
            valid_d = valid_d;
        end
        if (new_push_s) begin
            valid_d[wr_ptr_q] = 1'b1;
        end else begin
            valid_d = valid_d;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= {DEPTH{1'b0}};
        end else begin
            valid_q <= valid_d;
        end
    end

    // Index shadow used only for the merge compare; not reset, like the storage.
    always_ff @(posedge clk) begin
        if (new_push_s) begin
            tag_q[wr_ptr_q] <= push_addr;
        end
    end
`else
    assign merge_s     = 1'b0;
    assign ram_waddr_s = wr_ptr_q;
`endif

    assign new_push_s = push && !merge_s && (!full_s || pop);
    assign drop_s     = push && !merge_s && full_s && !pop;
    assign ram_we_s   = new_push_s || merge_s;

    refill_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (ram_waddr_s),
        .wdata_i ({push_addr, push_data}),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata_s)
    );

    // Next-state for pointers, occupancy, output registers and sticky error flags.
    always_comb begin
        wr_ptr_d    = new_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d    = pop_acc_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc_s;
        pop_data_d  = pop_data_q;
        pop_addr_d  = pop_addr_q;
        case ({new_push_s, pop_acc_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (pop_acc_s) begin
            {pop_addr_d, pop_data_d} = ram_rdata_s;
        end else begin
            pop_data_d = pop_data_q;
        end
        overflow_d  = drop_s || (overflow_q && !clear_err);
        underflow_d = (pop && empty_s) || (underflow_q && !clear_err);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            pop_data_q  <= {DATA_WIDTH{1'b0}};
            pop_addr_q  <= {ADDR_WIDTH{1'b0}};
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_addr_q  <= pop_addr_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign pop_data    = pop_data_q;
    assign pop_addr    = pop_addr_q;
    assign pop_valid   = pop_valid_q;
    assign full        = full_s;
    assign empty       = empty_s;
    assign almost_full = (count_q >= CNT_W'(AFULL_LEVEL));
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule
